// File: rtl/gbe_pkg.sv
// -----------------------------------------------------------------------------
// gbe_pkg
// Shared constants and types for the gigabit Ethernet transmit path:
//   - preamble / SFD byte values and preamble length
//   - minimum frame length (payload before FCS) used for padding
//   - CRC-32 polynomial (normal form), initial value and good-frame residue
//   - transmit framer state encoding
//   - reverse32(): bit reversal helper (normal <-> reflected CRC forms)
// The PAD state only exists when GBE_TX_FRAMER_PAD_EN is defined.
// -----------------------------------------------------------------------------
package gbe_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          MIN_FRAME_LEN = 60;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Normal-form register value left after running the CRC over data + FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
`ifdef GBE_TX_FRAMER_PAD_EN
    ST_PAD      = 3'd4,
`endif
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_e;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/gbe_crc32_d8.sv
// -----------------------------------------------------------------------------
// gbe_crc32_d8
// Combinational one-byte CRC-32 step in the reflected (LSB-first) form used by
// Ethernet: bit 0 of each byte is folded in first.
// Ports:
//   crc      in  32  current CRC register (reflected form)
//   data     in  8   byte to fold in
//   crc_next out 32  register value after folding in data
// -----------------------------------------------------------------------------
module gbe_crc32_d8
  import gbe_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_REFL = reverse32(CRC_POLY);

  always_comb begin
    // NOTE: the output gets a value before the loop so every path assigns it
    // and no latch is inferred; blocking '=' is right inside combinational code.
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ POLY_REFL;
      else                       crc_next = crc_next >> 1;
    end
  end

endmodule

// File: rtl/gbe_tx_framer.sv
// -----------------------------------------------------------------------------
// gbe_tx_framer
// GMII transmit framer: wraps an upstream frame with preamble, SFD, optional
// padding to 60 bytes and a CRC-32 FCS, then enforces the inter-frame gap.
// Every GMII output is registered, so the wire shows what the FSM produced in
// the previous cycle (payload byte latency is one cycle).
//
// Build option: define GBE_TX_FRAMER_PAD_EN to pad short frames with 0x00 up
// to 60 bytes; without it frames go straight from payload to FCS.
//
// Parameters:
//   MAX_FRAME_LEN  bytes accepted before flagging oversize (must be < 2047)
//   IFG_CYCLES     idle wire cycles between back-to-back frames
// Ports:
//   mac_clk         in   1  clock, rising edge
//   mac_rst_n       in   1  asynchronous active-low reset
//   mac_tx_data     in   8  frame byte, destination MAC first
//   mac_tx_dvld     in   1  high from request until the last byte
//   mac_tx_ack      out  1  pulse: first byte sampled this cycle
//   gmii_txd        out  8  GMII transmit data
//   gmii_tx_en      out  1  GMII transmit enable
//   gmii_tx_er      out  1  GMII transmit error (oversize frames)
//   frame_sent      out  1  pulse with the last FCS byte on the wire
//   frame_oversize  out  1  pulse with the first byte beyond MAX_FRAME_LEN
// -----------------------------------------------------------------------------
module gbe_tx_framer
  import gbe_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1514,
  parameter int IFG_CYCLES    = 12
) (
  input  logic       mac_clk,
  input  logic       mac_rst_n,
  input  logic [7:0] mac_tx_data,
  input  logic       mac_tx_dvld,
  output logic       mac_tx_ack,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_sent,
  output logic       frame_oversize
);

  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
`ifdef GBE_TX_FRAMER_PAD_EN
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
`endif
  // The IDLE cycle that accepts the next request also puts an idle byte on
  // the wire, so IFG itself lasts one cycle less than the wire gap.
  localparam logic [15:0] IFG_LAST = 16'((IFG_CYCLES > 1) ? IFG_CYCLES - 2 : 0);

  tx_state_e   state;
  logic [2:0]  pre_cnt;
  logic [15:0] ifg_cnt;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [1:0]  fcs_idx;
  logic        first_data;
  logic        oversize;

  logic [7:0]  crc_byte;
  logic [31:0] crc_next;
  logic [31:0] fcs_val;
  logic [7:0]  fcs_byte;

  // Pad bytes fold in as zeros; the data input is only trusted inside DATA.
  assign crc_byte = (state == ST_DATA && mac_tx_dvld) ? mac_tx_data : 8'h00;
  assign fcs_val  = ~crc;
  assign fcs_byte = fcs_val[{fcs_idx, 3'b000} +: 8];

  assign mac_tx_ack = (state == ST_DATA) && first_data;

  gbe_crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_byte),
    .crc_next (crc_next)
  );

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      // NOTE: only control state and output registers live here, so every one
      // of them gets a reset value; mid-frame reset must leave nothing stale.
      state          <= ST_IDLE;
      pre_cnt        <= '0;
      ifg_cnt        <= '0;
      byte_cnt       <= '0;
      crc            <= CRC_INIT;
      fcs_idx        <= '0;
      first_data     <= 1'b0;
      oversize       <= 1'b0;
      gmii_txd       <= 8'h00;
      gmii_tx_en     <= 1'b0;
      gmii_tx_er     <= 1'b0;
      frame_sent     <= 1'b0;
      frame_oversize <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' everywhere in clocked logic so all registers
      // update from the same pre-edge values.
      frame_sent     <= 1'b0;
      frame_oversize <= 1'b0;

      case (state)
        ST_IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          pre_cnt    <= '0;
          byte_cnt   <= '0;
          crc        <= CRC_INIT;
          fcs_idx    <= '0;
          oversize   <= 1'b0;
          if (mac_tx_dvld) state <= ST_PREAMBLE;
        end

        ST_PREAMBLE: begin
          gmii_txd   <= PREAMBLE_BYTE;
          gmii_tx_en <= 1'b1;
          if (pre_cnt == 3'(PREAMBLE_LEN - 1)) state <= ST_SFD;
          else                                  pre_cnt <= pre_cnt + 3'd1;
        end

        ST_SFD: begin
          gmii_txd   <= SFD_BYTE;
          gmii_tx_en <= 1'b1;
          first_data <= 1'b1;
          state      <= ST_DATA;
        end

        // The cycle that sees dvld low already emits the first pad or FCS
        // byte, keeping the wire contiguous.
        ST_DATA: begin
          first_data <= 1'b0;
          gmii_tx_en <= 1'b1;
          if (mac_tx_dvld) begin
            gmii_txd <= mac_tx_data;
            crc      <= crc_next;
            byte_cnt <= (&byte_cnt) ? byte_cnt : byte_cnt + 11'd1;
            if (!oversize && byte_cnt == MAX_LEN) begin
              oversize       <= 1'b1;
              frame_oversize <= 1'b1;
              gmii_tx_er     <= 1'b1;
            end else begin
              gmii_tx_er <= oversize;
            end
          end
`ifdef GBE_TX_FRAMER_PAD_EN
          else if (byte_cnt < MIN_LEN) begin
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b0;
            crc        <= crc_next;
            byte_cnt   <= byte_cnt + 11'd1;
            state      <= (byte_cnt == MIN_LEN - 11'd1) ? ST_FCS : ST_PAD;
          end
`endif
          else begin
            gmii_txd   <= fcs_byte;
            gmii_tx_er <= oversize;
            fcs_idx    <= fcs_idx + 2'd1;
            state      <= ST_FCS;
          end
        end

`ifdef GBE_TX_FRAMER_PAD_EN
        ST_PAD: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b1;
          gmii_tx_er <= 1'b0;
          crc        <= crc_next;
          byte_cnt   <= byte_cnt + 11'd1;
          if (byte_cnt == MIN_LEN - 11'd1) state <= ST_FCS;
        end
`endif

        ST_FCS: begin
          gmii_txd   <= fcs_byte;
          gmii_tx_en <= 1'b1;
          gmii_tx_er <= oversize;
          fcs_idx    <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            frame_sent <= 1'b1;
            ifg_cnt    <= '0;
            state      <= ST_IFG;
          end
        end

        ST_IFG: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          if (ifg_cnt == IFG_LAST) state   <= ST_IDLE;
          else                     ifg_cnt <= ifg_cnt + 16'd1;
        end

        default: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbe_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_gbe_tx_framer
// Directed bench for gbe_tx_framer (default parameters). Drives upstream frames
// with a counting byte pattern, captures every tx_en byte off the GMII wire and
// checks framing, padding, FCS residue, IFG, oversize flagging and reset.
// Expectations follow GBE_TX_FRAMER_PAD_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_gbe_tx_framer;

`ifdef GBE_TX_FRAMER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       mac_clk = 1'b0;
  logic       mac_rst_n;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_ack;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       frame_sent;
  logic       frame_oversize;

  gbe_tx_framer dut (
    .mac_clk        (mac_clk),
    .mac_rst_n      (mac_rst_n),
    .mac_tx_data    (mac_tx_data),
    .mac_tx_dvld    (mac_tx_dvld),
    .mac_tx_ack     (mac_tx_ack),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .frame_sent     (frame_sent),
    .frame_oversize (frame_oversize)
  );

  always #4 mac_clk = ~mac_clk;

  int n_tests = 0;
  int n_fails = 0;

  // Capture of the most recent frame.
  logic [7:0] wire_q[$];
  int en_cycles, er_cnt, er_first, ack_cnt, ovs_cnt, ovs_at, gap_cnt, lead_low;
  bit frame_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mac_clk);
    #1;
  endtask

  // Normal-form CRC-32 over the captured bytes after the SFD, each byte fed
  // LSB first; a good frame leaves the well-known residue.
  function automatic logic [31:0] wire_residue();
    logic [31:0] r = 32'hFFFFFFFF;
    logic [7:0]  b;
    for (int i = 8; i < wire_q.size(); i++) begin
      b = wire_q[i];
      for (int k = 0; k < 8; k++) begin
        if (r[31] ^ b[k]) r = (r << 1) ^ 32'h04C11DB7;
        else              r = r << 1;
      end
    end
    return r;
  endfunction

  // Plays upstream for one frame of len bytes (seed, seed+1, ...) and records
  // the wire until frame_sent. Call right after a rising edge.
  task automatic send_frame(input int len, input logic [7:0] seed);
    int  sent = 0;
    int  cyc  = 0;
    bit  started = 0;
    bit  take;
    wire_q.delete();
    en_cycles = 0; er_cnt = 0; er_first = -1; ack_cnt = 0;
    ovs_cnt = 0; ovs_at = -1; gap_cnt = 0; lead_low = 0; frame_done = 0;
    mac_tx_dvld = 1'b1;
    mac_tx_data = seed;
    while (!frame_done && cyc < 4000) begin
      @(negedge mac_clk);
      cyc++;
      if (gmii_tx_en) begin
        wire_q.push_back(gmii_txd);
        en_cycles++;
        if (gmii_tx_er) begin
          if (er_first < 0) er_first = wire_q.size() - 1;
          er_cnt++;
        end
      end else if (wire_q.size() == 0) begin
        lead_low++;
      end else begin
        gap_cnt++;
      end
      if (frame_oversize) begin
        ovs_cnt++;
        ovs_at = wire_q.size() - 1;
      end
      if (mac_tx_ack) begin
        ack_cnt++;
        started = 1;
      end
      take = started && mac_tx_dvld;
      if (frame_sent) frame_done = 1;
      @(posedge mac_clk);
      #1;
      if (len == 0 && cyc == 1) mac_tx_dvld = 1'b0;
      if (take) begin
        sent++;
        if (sent >= len) mac_tx_dvld = 1'b0;
        else             mac_tx_data = 8'(seed + 8'(sent));
      end
    end
    mac_tx_dvld = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int len, input logic [7:0] seed);
    int pl = (PAD_EN && len < 60) ? 60 : len;
    int bad_pre = 0, bad_dat = 0, bad_pad = 0;
    check({tag, "_sent"}, 32'(frame_done), 32'd1);
    check({tag, "_wire_len"}, wire_q.size(), 8 + pl + 4);
    check({tag, "_en_cycles"}, en_cycles, 8 + pl + 4);
    check({tag, "_en_gap"}, gap_cnt, 0);
    for (int i = 0; i < 7; i++)
      if (i >= wire_q.size() || wire_q[i] !== 8'h55) bad_pre++;
    check({tag, "_preamble_bad"}, bad_pre, 0);
    check({tag, "_sfd"}, (wire_q.size() > 7) ? 32'(wire_q[7]) : 32'hDEAD, 32'hD5);
    for (int i = 0; i < len; i++)
      if (8 + i >= wire_q.size() || wire_q[8 + i] !== 8'(seed + 8'(i))) bad_dat++;
    check({tag, "_data_bad"}, bad_dat, 0);
    for (int i = len; i < pl; i++)
      if (8 + i >= wire_q.size() || wire_q[8 + i] !== 8'h00) bad_pad++;
    check({tag, "_pad_bad"}, bad_pad, 0);
    check({tag, "_residue"}, wire_residue(), 32'hC704DD7B);
    if (len > 0) check({tag, "_ack"}, ack_cnt, 1);
    if (len <= 1514) begin
      check({tag, "_er_cnt"}, er_cnt, 0);
      check({tag, "_oversize"}, ovs_cnt, 0);
    end
  endtask

  initial begin : stim
    int  sent;
    bit  started;
    bit  take;

    // Reset state
    mac_rst_n   = 1'b0;
    mac_tx_dvld = 1'b0;
    mac_tx_data = 8'h00;
    idle(3);
    check("rst_txd", gmii_txd, 8'h00);
    check("rst_tx_en", gmii_tx_en, 1'b0);
    check("rst_tx_er", gmii_tx_er, 1'b0);
    check("rst_ack", mac_tx_ack, 1'b0);
    check("rst_sent", frame_sent, 1'b0);
    check("rst_ovs", frame_oversize, 1'b0);
    @(negedge mac_clk);
    mac_rst_n = 1'b1;
    idle(1);

    // 60-byte frame 0x00..0x3B, first frame after reset starts without IFG
    send_frame(60, 8'h00);
    check("f60_lead_idle", lead_low, 2);
    check_frame("f60", 60, 8'h00);

    // Back-to-back: request one cycle after frame_sent
    send_frame(14, 8'hA0);
    check("b2b_ifg", lead_low, 12);
    check_frame("f14", 14, 8'hA0);

    // One byte short of the minimum
    idle(20);
    send_frame(59, 8'h10);
    check_frame("f59", 59, 8'h10);

    // Zero-length frame: dvld is a one-cycle request only
    idle(20);
    send_frame(0, 8'h00);
    check_frame("f0", 0, 8'h00);

    // Exactly MAX_FRAME_LEN: no oversize
    idle(20);
    send_frame(1514, 8'h33);
    check_frame("f1514", 1514, 8'h33);

    // Oversize: byte 1515 sits at wire index 8+1514
    idle(20);
    send_frame(1600, 8'h77);
    check_frame("f1600", 1600, 8'h77);
    check("ovs_pulses", ovs_cnt, 1);
    check("ovs_at", ovs_at, 1522);
    check("er_first", er_first, 1522);
    check("er_cnt", er_cnt, 86 + 4);

    // Reset in the middle of the payload (data byte 30 on the wire)
    idle(20);
    mac_tx_dvld = 1'b1;
    mac_tx_data = 8'h00;
    sent = 0;
    started = 0;
    for (int cyc = 0; cyc < 100 && sent < 30; cyc++) begin
      @(negedge mac_clk);
      if (mac_tx_ack) started = 1;
      take = started && mac_tx_dvld;
      @(posedge mac_clk);
      #1;
      if (take) begin
        sent++;
        mac_tx_data = 8'(sent);
      end
    end
    check("mid_bytes_sent", sent, 30);
    check("mid_tx_en", gmii_tx_en, 1'b1);
    check("mid_txd", gmii_txd, 8'd29);
    #2;
    mac_rst_n = 1'b0;
    #1;
    check("mid_rst_txd", gmii_txd, 8'h00);
    check("mid_rst_tx_en", gmii_tx_en, 1'b0);
    check("mid_rst_tx_er", gmii_tx_er, 1'b0);
    check("mid_rst_ack", mac_tx_ack, 1'b0);
    check("mid_rst_sent", frame_sent, 1'b0);
    check("mid_rst_ovs", frame_oversize, 1'b0);
    mac_tx_dvld = 1'b0;
    idle(2);
    @(negedge mac_clk);
    mac_rst_n = 1'b1;
    idle(1);
    send_frame(20, 8'h40);
    check("post_rst_lead_idle", lead_low, 2);
    check_frame("post_rst", 20, 8'h40);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/gbe_tx_framer.md
GBE_TX_FRAMER -- requirements
Module: gbe_tx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1514, max bytes accepted from upstream per frame (excl. FCS).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, minimum idle cycles between frames.
REQ-003 SHALL have port mac_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port mac_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port mac_tx_data  in  8  frame byte from gbe_tx (dest MAC first).
REQ-006 SHALL have port mac_tx_dvld  in  1  frame request/valid; high from request until last byte.
REQ-007 SHALL have port mac_tx_ack  out  1  one-cycle pulse; first byte sampled this cycle.
REQ-008 SHALL have port gmii_txd  out  8  registered GMII transmit data.
REQ-009 SHALL have port gmii_tx_en  out  1  registered GMII transmit enable.
REQ-010 SHALL have port gmii_tx_er  out  1  registered GMII transmit error.
REQ-011 SHALL have port frame_sent  out  1  one-cycle pulse after last FCS byte.
REQ-012 SHALL have port frame_oversize  out  1  one-cycle pulse when byte count exceeds MAX_FRAME_LEN.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-014 IDLE: mac_tx_dvld high -> PREAMBLE; mac_tx_dvld is not otherwise sampled outside DATA.
REQ-015 PREAMBLE: 7 cycles driving 0x55, gmii_tx_en=1; then SFD: 1 cycle driving 0xD5.
REQ-016 mac_tx_ack SHALL be combinational, high only in the first DATA cycle.
REQ-017 DATA: each cycle with mac_tx_dvld=1 samples mac_tx_data, appears on gmii_txd next cycle (latency 1), folds into CRC, increments 11-bit byte count (saturating at 2047).
REQ-018 DATA with mac_tx_dvld=0 (incl. first cycle: zero-length frame) ends payload -> PAD if count<60 (pad enabled), else FCS.
REQ-019 PAD: drive 0x00, include in CRC, until count=60, then FCS.
REQ-020 FCS: 4 cycles, CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final inverted), LS byte first; CRC excludes preamble/SFD.
REQ-021 On final FCS cycle pulse frame_sent next cycle; go to IFG.
REQ-022 IFG: gmii_tx_en=0, gmii_txd=0x00 for IFG_CYCLES cycles, then IDLE; dvld during IFG waits.
REQ-023 Count exceeding MAX_FRAME_LEN: pulse frame_oversize once; gmii_tx_er=1 for remaining data and FCS bytes; frame continues until dvld low.
REQ-024 gmii_tx_en SHALL be high exactly from first preamble byte to last FCS byte inclusive.

Reset
REQ-025 mac_rst_n low SHALL immediately force IDLE, gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, mac_tx_ack=0, frame_sent=0, frame_oversize=0, count=0, CRC=0xFFFFFFFF, including mid-frame.
REQ-026 After reset release, first frame SHALL not wait for IFG.

Configuration
REQ-027 Macro GBE_TX_FRAMER_PAD_EN defined: short frames padded to 60 bytes per REQ-019.
REQ-028 Macro undefined: PAD state absent; DATA goes directly to FCS regardless of length.

Structure
REQ-029 Shared package gbe_pkg SHALL hold preamble 0x55, SFD 0xD5, min frame 60, CRC poly/init, CRC residue 0xC704DD7B, state encoding.
REQ-030 CRC update SHALL be a sub-module gbe_crc32_d8 (8-bit combinational next-CRC); FSM, counters, output registers in gbe_tx_framer.

Verification
REQ-031 60-byte frame 0x00..0x3B -> 7x0x55, 0xD5, 60 data bytes, 4 FCS bytes; tx_en high 72 cycles; ack one pulse.
REQ-032 14-byte frame (pad enabled) -> 46 0x00 bytes appended, tx_en 72 cycles; pad disabled -> tx_en 26 cycles.
REQ-033 Any frame: CRC-32 over data+pad+FCS at checker equals residue 0xC704DD7B.
REQ-034 Back-to-back: dvld high again one cycle after frame_sent -> exactly 12 tx_en-low cycles before next 0x55.
REQ-035 1600-byte frame, MAX_FRAME_LEN=1514 -> frame_oversize pulse at byte 1515; tx_er high bytes 1515..1600 and FCS.
REQ-036 mac_rst_n low at data byte 30 -> all outputs zero that cycle; next frame after release starts with full preamble.
